alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B; shift amount for SLL is b[log2(WIDTH)-1:0].
REQ-008 SHALL have port alu_control  input  4  op: 0000 ADD, 0001 OR, 0010 AND, 0011 SLL, 0100 BNE.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  registered flag, 1 iff result == 0.
REQ-013 SHALL have port rsp_err  output  1  registered flag, 1 iff alu_control was not a defined op.

Function
REQ-014 SHALL implement states IDLE, SHIFT, RESP; req_ready = 1 only in IDLE with reset low.
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready, latching a, b, alu_control.
REQ-016 ADD SHALL produce (a + b) mod 2^WIDTH, carry discarded; OR a|b; AND a&b; SLL a << shamt, zero-filled.
REQ-017 BNE SHALL produce result 1 if a != b, else 0 (so zero = 1 when a == b).
REQ-018 Undefined alu_control SHALL produce result 0, zero 1, rsp_err 1; all defined ops SHALL give rsp_err 0.
REQ-019 Non-iterative ops SHALL move IDLE -> RESP at the accept edge; rsp_valid high the following cycle (latency 1).
REQ-020 In RESP, result/zero/rsp_err SHALL hold stable until the edge where rsp_valid && rsp_ready, then go to IDLE.
REQ-021 SHALL NOT accept a new request in the same cycle a response is consumed; next accept earliest one cycle later.
REQ-022 req_valid or operand changes outside IDLE SHALL have no effect.
REQ-023 rsp_ready asserted while rsp_valid is low SHALL have no effect.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, rsp_valid 0, result 0, zero 0, rsp_err 0, shift counter 0, from any state including mid-SHIFT or RESP.
REQ-025 req_ready SHALL be 0 while reset is high; an in-flight operation SHALL be discarded with no response.

Configuration
REQ-026 Macro ALU_ITERATIVE_SHIFT_EN SHALL select the SLL implementation.
REQ-027 Defined: SLL with shamt > 0 SHALL go IDLE -> SHIFT, shift left 1 bit per cycle decrementing a counter loaded with shamt, enter RESP when counter reaches 0; rsp_valid high shamt+1 cycles after accept.
REQ-028 Defined: SLL with shamt = 0 SHALL go directly to RESP, latency 1, result = a.
REQ-029 Not defined: SLL SHALL use a single-cycle shifter, latency 1, SHIFT state unreachable; results identical in both builds.

Verification
REQ-030 ADD a=10, b=15, rsp_ready=1 -> rsp_valid 1 cycle after accept, result 25, zero 0, rsp_err 0.
REQ-031 OR a=0, b=0 -> result 0, zero 1; OR a=FF00FF00h, b=00FF00FFh -> result FFFFFFFFh, zero 0.
REQ-032 SLL a=1, b=4 -> result 16; with ALU_ITERATIVE_SHIFT_EN rsp_valid 5 cycles after accept, req_ready 0 throughout; without, 1 cycle.
REQ-033 BNE a=20, b=25 -> result 1, zero 0; BNE a=30, b=30 -> result 0, zero 1; alu_control=1111 -> result 0, zero 1, rsp_err 1.
REQ-034 AND a=A5A5A5A5h, b=5A5A5A5Ah with rsp_ready=0 for 3 cycles -> result 0, zero 1 held stable, rsp_valid 1 until rsp_ready, req_ready 0 until the cycle after hand-off.
REQ-035 Reset asserted 2 cycles into SLL a=1, b=20 (iterative build) -> next cycle rsp_valid 0, result 0, req_ready 1 once reset low; no response emitted.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked sequential ALU (ADD, OR, AND, SLL, BNE) with a
// registered result, zero flag and undefined-op error flag.
// Build option: define ALU_ITERATIVE_SHIFT_EN to run SLL as a one-bit-per-cycle
// shifter through the SHIFT state; otherwise SLL uses a single-cycle shifter.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             rsp_err
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_BNE = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_err;
    logic [SHW-1:0]   w_shamt;
    logic             w_start_shift;

    assign w_shamt = b[SHW-1:0];

`ifdef ALU_ITERATIVE_SHIFT_EN
    logic [SHW-1:0] r_cnt;
    assign w_start_shift = (alu_control == OP_SLL) && (w_shamt != '0);
`else
    assign w_start_shift = 1'b0;
`endif

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign rsp_valid = (r_state == S_RESP);
    assign result    = r_result;
    assign zero      = r_zero;
    assign rsp_err   = r_err;

    // Single-cycle operation result computed from the live request inputs
    always_comb begin
        w_alu_result = '0;
        w_err        = 1'b0;
        case (alu_control)
            OP_ADD: w_alu_result = a + b;
            OP_OR:  w_alu_result = a | b;
            OP_AND: w_alu_result = a & b;
`ifdef ALU_ITERATIVE_SHIFT_EN
            // Only reached with shamt == 0; non-zero shifts go through SHIFT
            OP_SLL: w_alu_result = a;
`else
            OP_SLL: w_alu_result = a << w_shamt;
`endif
            OP_BNE: w_alu_result = WIDTH'(a != b);
            default: w_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_start_shift ? S_SHIFT : S_RESP;
                end
            end
            S_SHIFT: begin
`ifdef ALU_ITERATIVE_SHIFT_EN
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result, flags and shift counter; held unchanged while in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_ITERATIVE_SHIFT_EN
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_start_shift) begin
                            r_result <= a;
                            r_zero   <= 1'b0;
                            r_err    <= 1'b0;
`ifdef ALU_ITERATIVE_SHIFT_EN
                            r_cnt    <= w_shamt;
`endif
                        end else begin
                            r_result <= w_alu_result;
                            r_zero   <= (w_alu_result == '0);
                            r_err    <= w_err;
                        end
                    end
                end
`ifdef ALU_ITERATIVE_SHIFT_EN
                S_SHIFT: begin
                    // Zero flag is settled on the exit edge, once shifting is done
                    if (r_cnt != '0) begin
                        r_result <= r_result << 1;
                        r_cnt    <= r_cnt - 1'b1;
                    end else begin
                        r_zero   <= (r_result == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH = 32), either SLL build.
module tb_alu_seq_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        zero;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    // expected {err, zero, result} of responses not yet consumed
    logic [33:0] exp_q[$];

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .result      (result),
        .zero        (zero),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the operation definitions
    function automatic logic [33:0] model_out(input logic [3:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [31:0] r;
        logic        e;
        logic [4:0]  sh;
        r  = '0;
        e  = 1'b0;
        sh = y[4:0];
        case (op)
            4'd0: r = 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
            4'd1: r = x | y;
            4'd2: r = x & y;
            4'd3: r = 32'(64'(x) * (64'd1 << sh));
            4'd4: r = (x == y) ? 32'd0 : 32'd1;
            default: e = 1'b1;
        endcase
        return {e, (r == 32'd0), r};
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] y);
        int lat;
        lat = 1;
`ifdef ALU_ITERATIVE_SHIFT_EN
        if (op == 4'd3 && y[4:0] != 5'd0) lat = int'(y[4:0]) + 1;
`endif
        return lat;
    endfunction

    // Compare process: every cycle a response is presented it must match the model
    always @(negedge clk) begin
        if (reset) begin
            chk("req_ready_in_reset", 64'(req_ready), 64'd0);
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                chk("model_result", 64'(result), 64'(exp_q[0][31:0]));
                chk("model_zero", 64'(zero), 64'(exp_q[0][32]));
                chk("model_err", 64'(rsp_err), 64'(exp_q[0][33]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One full transaction with literal expectations; starts and ends at posedge+1
    task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int hold, input logic [31:0] er,
                         input logic ez, input logic ee);
        int wait_n;
        int lat;
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (!req_ready) chk({nm, "_ready_timeout"}, 64'(req_ready), 64'd1);
        req_valid   = 1'b1;
        a           = x;
        b           = y;
        alu_control = op;
        rsp_ready   = 1'b1;   // consumer ready while no response: must be ignored
        @(posedge clk); #1;
        exp_q.push_back(model_out(op, x, y));
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        a           = $urandom;
        b           = $urandom;
        alu_control = 4'($urandom_range(0, 15));
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            chk({nm, "_busy_ready"}, 64'(req_ready), 64'd0);
            req_valid = 1'b1;   // requests while busy must be ignored
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_latency(op, y)));
        chk({nm, "_result"}, 64'(result), 64'(er));
        chk({nm, "_zero"}, 64'(zero), 64'(ez));
        chk({nm, "_err"}, 64'(rsp_err), 64'(ee));
        chk({nm, "_rsp_ready_lo"}, 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            a         = $urandom;
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, "_hold_result"}, 64'(result), 64'(er));
            chk({nm, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, "_done_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        a           = '0;
        b           = '0;
        alu_control = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        do_op("add_10_15",  4'd0, 32'd10,         32'd15,         0, 32'd25,         1'b0, 1'b0);
        do_op("add_wrap",   4'd0, 32'hFFFF_FFFF,  32'd1,          0, 32'd0,          1'b1, 1'b0);
        do_op("or_zero",    4'd1, 32'd0,          32'd0,          0, 32'd0,          1'b1, 1'b0);
        do_op("or_ones",    4'd1, 32'hFF00_FF00,  32'h00FF_00FF,  1, 32'hFFFF_FFFF,  1'b0, 1'b0);
        do_op("and_hold",   4'd2, 32'hA5A5_A5A5,  32'h5A5A_5A5A,  3, 32'd0,          1'b1, 1'b0);
        do_op("and_mix",    4'd2, 32'hFFFF_0000,  32'h0F0F_0F0F,  0, 32'h0F0F_0000,  1'b0, 1'b0);
        do_op("sll_1_4",    4'd3, 32'd1,          32'd4,          0, 32'd16,         1'b0, 1'b0);
        do_op("sll_sh0",    4'd3, 32'd5,          32'd0,          0, 32'd5,          1'b0, 1'b0);
        do_op("sll_31",     4'd3, 32'd1,          32'd31,         0, 32'h8000_0000,  1'b0, 1'b0);
        do_op("sll_mask",   4'd3, 32'd3,          32'd33,         0, 32'd6,          1'b0, 1'b0);
        do_op("sll_out",    4'd3, 32'h8000_0000,  32'd1,          2, 32'd0,          1'b1, 1'b0);
        do_op("bne_ne",     4'd4, 32'd20,         32'd25,         0, 32'd1,          1'b0, 1'b0);
        do_op("bne_eq",     4'd4, 32'd30,         32'd30,         0, 32'd0,          1'b1, 1'b0);
        do_op("undef_f",    4'hF, 32'd7,          32'd9,          0, 32'd0,          1'b1, 1'b1);
        do_op("undef_5",    4'd5, 32'hFFFF_FFFF,  32'd1,          1, 32'd0,          1'b1, 1'b1);

        // Reset two cycles into a long shift: operation discarded, no response
        req_valid   = 1'b1;
        a           = 32'd1;
        b           = 32'd20;
        alu_control = 4'd3;
        @(posedge clk); #1;
        exp_q.push_back(model_out(4'd3, 32'd1, 32'd20));
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd0);
        chk("midrst_err", 64'(rsp_err), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(req_ready), 64'd1);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        do_op("add_after_rst", 4'd0, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
